// File: rtl/fft16_pkg.sv
// fft16_pkg: widths, complex types, W16 twiddle constants and FSM states for the 16-point FFT.
// The FFT_ROUND_EN macro in fft16_wrap chooses between rounding and truncating the twiddle products.
package fft16_pkg;

  localparam int IN_W    = 16;
  localparam int S1_W    = IN_W + 2;
  localparam int TWO_W   = S1_W + 1;
  localparam int OUT_W   = TWO_W + 2;
  localparam int TW_W    = 16;
  localparam int TW_FRAC = 14;

  typedef struct packed {
    logic [IN_W-1:0] im;
    logic [IN_W-1:0] re;
  } cplx_in_t;

  typedef struct packed {
    logic [S1_W-1:0] im;
    logic [S1_W-1:0] re;
  } cplx_s1_t;

  typedef struct packed {
    logic [TWO_W-1:0] im;
    logic [TWO_W-1:0] re;
  } cplx_tw_t;

  typedef struct packed {
    logic [OUT_W-1:0] im;
    logic [OUT_W-1:0] re;
  } cplx_out_t;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_ST1, S_ST2, S_STORE, S_DONE
  } state_t;

  // W16^m = cos - j*sin in Q1.14; only m = n2*k1 in 0..9 is ever needed
  function automatic logic signed [TW_W-1:0] tw_cos(input int m);
    case (m)
      0:       tw_cos = 16'sd16384;
      1:       tw_cos = 16'sd15137;
      2:       tw_cos = 16'sd11585;
      3:       tw_cos = 16'sd6270;
      5:       tw_cos = -16'sd6270;
      6:       tw_cos = -16'sd11585;
      7:       tw_cos = -16'sd15137;
      8:       tw_cos = -16'sd16384;
      9:       tw_cos = -16'sd15137;
      default: tw_cos = 16'sd0;
    endcase
  endfunction

  function automatic logic signed [TW_W-1:0] tw_sin(input int m);
    case (m)
      1:       tw_sin = 16'sd6270;
      2:       tw_sin = 16'sd11585;
      3:       tw_sin = 16'sd15137;
      4:       tw_sin = 16'sd16384;
      5:       tw_sin = 16'sd15137;
      6:       tw_sin = 16'sd11585;
      7:       tw_sin = 16'sd6270;
      9:       tw_sin = -16'sd6270;
      default: tw_sin = 16'sd0;
    endcase
  endfunction

endpackage

// File: rtl/fft16_bfly4.sv
// fft16_bfly4: combinational 4-point DFT (W4 = -j), adds/subtracts only, output grows by 2 bits.
// Element n of each flattened input occupies bits [n*W +: W]; output element k likewise.
module fft16_bfly4 #(
  parameter int W = 16
) (
  input  logic [4*W-1:0]     re_i,
  input  logic [4*W-1:0]     im_i,
  output logic [4*(W+2)-1:0] re_o,
  output logic [4*(W+2)-1:0] im_o
);

  localparam int OW = W + 2;

  logic signed [OW-1:0] ar, ai, br, bi, cr, ci, dr, di;

  assign ar = {{2{re_i[1*W-1]}}, re_i[0*W +: W]};
  assign ai = {{2{im_i[1*W-1]}}, im_i[0*W +: W]};
  assign br = {{2{re_i[2*W-1]}}, re_i[1*W +: W]};
  assign bi = {{2{im_i[2*W-1]}}, im_i[1*W +: W]};
  assign cr = {{2{re_i[3*W-1]}}, re_i[2*W +: W]};
  assign ci = {{2{im_i[3*W-1]}}, im_i[2*W +: W]};
  assign dr = {{2{re_i[4*W-1]}}, re_i[3*W +: W]};
  assign di = {{2{im_i[4*W-1]}}, im_i[3*W +: W]};

  // -j*(r + j i) = i - j r ; +j*(r + j i) = -i + j r
  assign re_o[0*OW +: OW] = ar + br + cr + dr;
  assign im_o[0*OW +: OW] = ai + bi + ci + di;
  assign re_o[1*OW +: OW] = ar + bi - cr - di;
  assign im_o[1*OW +: OW] = ai - br - ci + dr;
  assign re_o[2*OW +: OW] = ar - br + cr - dr;
  assign im_o[2*OW +: OW] = ai - bi + ci - di;
  assign re_o[3*OW +: OW] = ar - bi - cr + di;
  assign im_o[3*OW +: OW] = ai + br - ci - dr;

endmodule

// File: rtl/fft16_wrap.sv
// fft16_wrap: unscaled 16-point radix-4 DIT FFT, four-lane BRAM-style load/store, start/done handshake.
// Define FFT_ROUND_EN to round twiddle products half-up; otherwise they are truncated.
module fft16_wrap
  import fft16_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        done,
  output logic        idle,
  output logic        ready,
  output logic        inData_0_ce,
  output logic        inData_1_ce,
  output logic        inData_2_ce,
  output logic        inData_3_ce,
  input  logic [31:0] inData_0,
  input  logic [31:0] inData_1,
  input  logic [31:0] inData_2,
  input  logic [31:0] inData_3,
  output logic        outData_0_we,
  output logic        outData_1_we,
  output logic        outData_2_we,
  output logic        outData_3_we,
  output logic [41:0] outData_0,
  output logic [41:0] outData_1,
  output logic [41:0] outData_2,
  output logic [41:0] outData_3
);

  localparam int PROD_W = S1_W + TW_W + 1;
  localparam logic signed [PROD_W-1:0] RND_OFS = PROD_W'(1 << (TW_FRAC - 1));

  function automatic logic signed [TWO_W-1:0] tw_scale(input logic signed [PROD_W-1:0] p);
    logic signed [PROD_W-1:0] t;
`ifdef FFT_ROUND_EN
    t = (p + RND_OFS) >>> TW_FRAC;
`else
    t = p >>> TW_FRAC;
`endif
    return TWO_W'(t);
  endfunction

  function automatic cplx_tw_t tw_mul(input logic signed [S1_W-1:0] ar,
                                      input logic signed [S1_W-1:0] ai,
                                      input logic signed [TW_W-1:0] c,
                                      input logic signed [TW_W-1:0] s);
    logic signed [PROD_W-1:0] xr, xi, xc, xs, pr, pi;
    xr = PROD_W'(ar);
    xi = PROD_W'(ai);
    xc = PROD_W'(c);
    xs = PROD_W'(s);
    pr = xr * xc + xi * xs;
    pi = xi * xc - xr * xs;
    return {tw_scale(pi), tw_scale(pr)};
  endfunction

  state_t     state_q;
  logic [1:0] cnt_q;
  logic       ce_q, we_q, ready_q, done_q, idle_q, armed_q;

  cplx_in_t   in_w   [4];
  cplx_in_t   xin_q  [4][4];
  cplx_tw_t   b_d    [4][4];
  cplx_tw_t   b_q    [4][4];
  cplx_out_t  x_d    [4][4];
  cplx_out_t  xbuf_q [4][4];
  cplx_out_t  out_q  [4];

  assign in_w[0] = inData_0;
  assign in_w[1] = inData_1;
  assign in_w[2] = inData_2;
  assign in_w[3] = inData_3;

  // ST1: xin_q is [lane n1][element n2]; butterfly over n1 gives A[n2][k1], then twiddle
  for (genvar n2 = 0; n2 < 4; n2++) begin : g_st1
    logic [4*IN_W-1:0] re_in, im_in;
    logic [4*S1_W-1:0] re_out, im_out;
    for (genvar n1 = 0; n1 < 4; n1++) begin : g_in
      assign re_in[n1*IN_W +: IN_W] = xin_q[n1][n2].re;
      assign im_in[n1*IN_W +: IN_W] = xin_q[n1][n2].im;
    end
    fft16_bfly4 #(.W(IN_W)) u_bfly (
      .re_i(re_in), .im_i(im_in), .re_o(re_out), .im_o(im_out)
    );
    for (genvar k1 = 0; k1 < 4; k1++) begin : g_tw
      localparam int M = n2 * k1;
      logic signed [S1_W-1:0] ar, ai;
      assign ar = re_out[k1*S1_W +: S1_W];
      assign ai = im_out[k1*S1_W +: S1_W];
      if (M == 0) begin : g_bypass
        assign b_d[n2][k1] = {ai[S1_W-1], ai, ar[S1_W-1], ar};
      end else begin : g_mul
        assign b_d[n2][k1] = tw_mul(ar, ai, tw_cos(M), tw_sin(M));
      end
    end
  end

  // ST2: butterfly over n2 for each k1 gives X[k1+4*k2], i.e. lane k2, element k1
  for (genvar k1 = 0; k1 < 4; k1++) begin : g_st2
    logic [4*TWO_W-1:0] re_in, im_in;
    logic [4*OUT_W-1:0] re_out, im_out;
    for (genvar n2 = 0; n2 < 4; n2++) begin : g_in
      assign re_in[n2*TWO_W +: TWO_W] = b_q[n2][k1].re;
      assign im_in[n2*TWO_W +: TWO_W] = b_q[n2][k1].im;
    end
    fft16_bfly4 #(.W(TWO_W)) u_bfly (
      .re_i(re_in), .im_i(im_in), .re_o(re_out), .im_o(im_out)
    );
    for (genvar k2 = 0; k2 < 4; k2++) begin : g_out
      assign x_d[k2][k1] = {im_out[k2*OUT_W +: OUT_W], re_out[k2*OUT_W +: OUT_W]};
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == S_LOAD) begin
      for (int k = 0; k < 4; k++) xin_q[k][cnt_q] <= in_w[k];
    end
    if (state_q == S_ST1) b_q <= b_d;
    if (state_q == S_ST2) xbuf_q <= x_d;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 2'd0;
      ce_q    <= 1'b0;
      we_q    <= 1'b0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      idle_q  <= 1'b1;
      armed_q <= 1'b1;
      for (int k = 0; k < 4; k++) out_q[k] <= '0;
    end else begin
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      if (!start) armed_q <= 1'b1;
      case (state_q)
        S_IDLE: begin
          if (start && armed_q) begin
            state_q <= S_LOAD;
            cnt_q   <= 2'd0;
            ce_q    <= 1'b1;
            idle_q  <= 1'b0;
          end
        end
        S_LOAD: begin
          cnt_q <= cnt_q + 2'd1;
          if (cnt_q == 2'd2) ready_q <= 1'b1;
          if (cnt_q == 2'd3) begin
            ce_q    <= 1'b0;
            state_q <= S_ST1;
          end
        end
        S_ST1: state_q <= S_ST2;
        S_ST2: begin
          state_q <= S_STORE;
          cnt_q   <= 2'd0;
          we_q    <= 1'b1;
          for (int k = 0; k < 4; k++) out_q[k] <= x_d[k][0];
        end
        S_STORE: begin
          cnt_q <= cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            we_q    <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            for (int k = 0; k < 4; k++) out_q[k] <= xbuf_q[k][cnt_q + 2'd1];
          end
        end
        S_DONE: begin
          // a start still high here must drop before the next frame is accepted
          state_q <= S_IDLE;
          idle_q  <= 1'b1;
          armed_q <= !start;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign done         = done_q;
  assign idle         = idle_q;
  assign ready        = ready_q;
  assign inData_0_ce  = ce_q;
  assign inData_1_ce  = ce_q;
  assign inData_2_ce  = ce_q;
  assign inData_3_ce  = ce_q;
  assign outData_0_we = we_q;
  assign outData_1_we = we_q;
  assign outData_2_we = we_q;
  assign outData_3_we = we_q;
  assign outData_0    = out_q[0];
  assign outData_1    = out_q[1];
  assign outData_2    = out_q[2];
  assign outData_3    = out_q[3];

endmodule

// File: tb/tb_fft16_wrap.sv
// tb_fft16_wrap: randomized and directed frames through fft16_wrap, compared with a two-stage
// radix-4 arithmetic model; also exercises handshake, held start and reset during STORE.
module tb_fft16_wrap;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic done, idle, ready;
  logic inData_0_ce, inData_1_ce, inData_2_ce, inData_3_ce;
  logic [31:0] inData_0, inData_1, inData_2, inData_3;
  logic outData_0_we, outData_1_we, outData_2_we, outData_3_we;
  logic [41:0] outData_0, outData_1, outData_2, outData_3;

  fft16_wrap dut (
    .clk(clk), .rst(rst), .start(start), .done(done), .idle(idle), .ready(ready),
    .inData_0_ce(inData_0_ce), .inData_1_ce(inData_1_ce),
    .inData_2_ce(inData_2_ce), .inData_3_ce(inData_3_ce),
    .inData_0(inData_0), .inData_1(inData_1), .inData_2(inData_2), .inData_3(inData_3),
    .outData_0_we(outData_0_we), .outData_1_we(outData_1_we),
    .outData_2_we(outData_2_we), .outData_3_we(outData_3_we),
    .outData_0(outData_0), .outData_1(outData_1), .outData_2(outData_2), .outData_3(outData_3)
  );

  always #5 clk = ~clk;

  // source/sink buffers: lane k, address j holds sample/result 4k+j
  logic [31:0] src_mem [16];
  logic [41:0] got [16];
  logic [1:0]  src_addr [4];
  logic [1:0]  snk_addr [4];
  logic        ce_w [4];
  logic        we_w [4];
  logic [41:0] od_w [4];
  int ce_cnt = 0, we_cnt = 0, ready_cnt = 0, done_cnt = 0, ce_run = 0, ready_pos = 0;

  assign ce_w[0] = inData_0_ce;   assign ce_w[1] = inData_1_ce;
  assign ce_w[2] = inData_2_ce;   assign ce_w[3] = inData_3_ce;
  assign we_w[0] = outData_0_we;  assign we_w[1] = outData_1_we;
  assign we_w[2] = outData_2_we;  assign we_w[3] = outData_3_we;
  assign od_w[0] = outData_0;     assign od_w[1] = outData_1;
  assign od_w[2] = outData_2;     assign od_w[3] = outData_3;
  assign inData_0 = src_mem[{2'd0, src_addr[0]}];
  assign inData_1 = src_mem[{2'd1, src_addr[1]}];
  assign inData_2 = src_mem[{2'd2, src_addr[2]}];
  assign inData_3 = src_mem[{2'd3, src_addr[3]}];

  always @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 4; k++) begin
        src_addr[k] <= 2'd0;
        snk_addr[k] <= 2'd0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (ce_w[k]) src_addr[k] <= src_addr[k] + 2'd1;
        if (we_w[k]) begin
          got[{k[1:0], snk_addr[k]}] <= od_w[k];
          snk_addr[k] <= snk_addr[k] + 2'd1;
        end
      end
    end
    if (ce_w[0]) ce_run <= ce_run + 1; else ce_run <= 0;
    if (ce_w[0]) ce_cnt <= ce_cnt + 1;
    if (we_w[0]) we_cnt <= we_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
    if (ready) begin
      ready_cnt <= ready_cnt + 1;
      ready_pos <= ce_w[0] ? ce_run + 1 : 0;
    end
  end

  int n_tests = 0;
  int n_fail = 0;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // reference model
  int     xr [16], xi [16];
  longint er [16], ei [16];
  int     twc [10], tws [10];

  task automatic w4mul(input longint r, input longint i, input int p,
                       output longint orr, output longint oi);
    case (p % 4)
      0: begin orr = r;  oi = i;  end
      1: begin orr = i;  oi = -r; end
      2: begin orr = -r; oi = -i; end
      default: begin orr = -i; oi = r; end
    endcase
  endtask

  task automatic model();
    longint ar, ai, tr, ti, pr, pi, ofs;
    longint br [16], bi [16];
    int m;
`ifdef FFT_ROUND_EN
    ofs = 64'sd8192;
`else
    ofs = 64'sd0;
`endif
    for (int n2 = 0; n2 < 4; n2++) begin
      for (int k1 = 0; k1 < 4; k1++) begin
        ar = 0; ai = 0;
        for (int n1 = 0; n1 < 4; n1++) begin
          w4mul(xr[4*n1+n2], xi[4*n1+n2], n1*k1, tr, ti);
          ar += tr; ai += ti;
        end
        m = n2 * k1;
        if (m == 0) begin
          br[4*n2+k1] = ar; bi[4*n2+k1] = ai;
        end else begin
          pr = ar * twc[m] + ai * tws[m];
          pi = ai * twc[m] - ar * tws[m];
          br[4*n2+k1] = (pr + ofs) >>> 14;
          bi[4*n2+k1] = (pi + ofs) >>> 14;
        end
      end
    end
    for (int k1 = 0; k1 < 4; k1++) begin
      for (int k2 = 0; k2 < 4; k2++) begin
        ar = 0; ai = 0;
        for (int n2 = 0; n2 < 4; n2++) begin
          w4mul(br[4*n2+k1], bi[4*n2+k1], n2*k2, tr, ti);
          ar += tr; ai += ti;
        end
        er[k1+4*k2] = ar; ei[k1+4*k2] = ai;
      end
    end
  endtask

  function automatic longint gre(input int i);
    return longint'($signed(got[i][20:0]));
  endfunction

  function automatic longint gim(input int i);
    return longint'($signed(got[i][41:21]));
  endfunction

  task automatic run_frame(input string name);
    int cyc, ce0, we0, rdy0, dn0;
    model();
    for (int n = 0; n < 16; n++) src_mem[n] = {16'(xi[n]), 16'(xr[n])};
    @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);
    ce0 = ce_cnt; we0 = we_cnt; rdy0 = ready_cnt; dn0 = done_cnt;
    start = 1'b1;
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 5) check({name, " idle_busy"}, longint'(idle), 0);
    end while (!done && cyc < 40);
    check({name, " latency"}, cyc, 11);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("%s X%0d re", name, i), gre(i), er[i]);
      check($sformatf("%s X%0d im", name, i), gim(i), ei[i]);
    end
    repeat (3) @(negedge clk);
    check({name, " no_relaunch_idle"}, longint'(idle), 1);
    check({name, " ce_cycles"}, ce_cnt - ce0, 4);
    check({name, " we_cycles"}, we_cnt - we0, 4);
    check({name, " ready_pulses"}, ready_cnt - rdy0, 1);
    check({name, " ready_on_4th"}, ready_pos, 4);
    check({name, " done_pulses"}, done_cnt - dn0, 1);
    start = 1'b0;
  endtask

  task automatic rand_frame(input int amp);
    for (int n = 0; n < 16; n++) begin
      xr[n] = int'($urandom_range(2*amp)) - amp;
      xi[n] = int'($urandom_range(2*amp)) - amp;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int cyc;
    real ang;
    for (int m = 0; m < 10; m++) begin
      ang = 2.0 * 3.14159265358979323846 * m / 16.0;
      twc[m] = $rtoi($floor(16384.0 * $cos(ang) + 0.5));
      tws[m] = $rtoi($floor(16384.0 * $sin(ang) + 0.5));
    end
    for (int n = 0; n < 16; n++) src_mem[n] = 32'd0;

    repeat (3) @(negedge clk);
    check("rst idle", longint'(idle), 1);
    check("rst done", longint'(done), 0);
    check("rst ready", longint'(ready), 0);
    check("rst ce", longint'(inData_0_ce), 0);
    check("rst we", longint'(outData_0_we), 0);
    check("rst outData", longint'(outData_0), 0);
    rst = 1'b1;

    for (int n = 0; n < 16; n++) begin xr[n] = (n == 0) ? 1 : 0; xi[n] = 0; end
    run_frame("impulse");
    check("impulse X5 re", gre(5), 1);
    check("impulse X13 im", gim(13), 0);

    for (int n = 0; n < 16; n++) begin xr[n] = (n % 2 == 0) ? 100 : -100; xi[n] = 0; end
    run_frame("alt");
    check("alt X8 re", gre(8), 1600);
    check("alt X0 re", gre(0), 0);

    for (int n = 0; n < 16; n++) begin xr[n] = 32767; xi[n] = 32767; end
    run_frame("fullpos");
    check("fullpos X0 re", gre(0), 524272);
    check("fullpos X0 im", gim(0), 524272);

    for (int n = 0; n < 16; n++) begin xr[n] = -32768; xi[n] = -32768; end
    run_frame("fullneg");
    check("fullneg X0 re", gre(0), -524288);
    check("fullneg X0 im", gim(0), -524288);

    for (int f = 0; f < 4; f++) begin
      rand_frame(32767);
      run_frame($sformatf("rand%0d", f));
    end
    rand_frame(200);
    run_frame("rand_small");

    // reset while the result is being written
    rand_frame(32767);
    for (int n = 0; n < 16; n++) src_mem[n] = {16'(xi[n]), 16'(xr[n])};
    repeat (2) @(negedge clk);
    start = 1'b1;
    cyc = 0;
    do begin @(posedge clk); #1; cyc++; end while (!outData_0_we && cyc < 40);
    check("rst_mid reached_store", longint'(outData_0_we), 1);
    @(negedge clk); rst = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    check("rst_mid we", longint'(outData_0_we), 0);
    check("rst_mid done", longint'(done), 0);
    check("rst_mid idle", longint'(idle), 1);
    check("rst_mid outData", longint'(outData_2), 0);
    @(negedge clk); rst = 1'b1;

    rand_frame(32767);
    run_frame("after_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
